// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: mode encoding, BCD limits,
// digit width and small mode-decoding helpers.
package stopwatch_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] TENS_MAX = 4'd5;
  localparam logic [DIGIT_W-1:0] ONES_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PAUSED  = 2'd1,
    ST_ADJ_MIN = 2'd2,
    ST_ADJ_SEC = 2'd3
  } sw_state_e;

  // Mode requested by the switches: adjust beats pause, pause beats run.
  function automatic sw_state_e next_mode(input logic adj, input logic sel,
                                          input logic pause);
    sw_state_e res;
    res = ST_RUN;
    if (adj) begin
      res = sel ? ST_ADJ_SEC : ST_ADJ_MIN;
    end else if (pause) begin
      res = ST_PAUSED;
    end
    return res;
  endfunction

  function automatic logic is_adj(input sw_state_e s);
    return (s == ST_ADJ_MIN) || (s == ST_ADJ_SEC);
  endfunction

endpackage

// File: rtl/stopwatch_if.sv
// Bundle of the stopwatch controls and display outputs. The master side
// produces ticks and button levels, the slave side (the controller) produces
// the digits, blink requests and mode.
interface stopwatch_if;
  import stopwatch_pkg::*;

  logic               tick_1hz;
  logic               tick_2hz;
  logic               clr_d;
  logic               pause_d;
  logic               adj_d;
  logic               sel_d;
  logic [DIGIT_W-1:0] min_tens;
  logic [DIGIT_W-1:0] min_ones;
  logic [DIGIT_W-1:0] sec_tens;
  logic [DIGIT_W-1:0] sec_ones;
  logic               blink_min;
  logic               blink_sec;
  logic [1:0]         mode;

  modport master (
    output tick_1hz, tick_2hz, clr_d, pause_d, adj_d, sel_d,
    input  min_tens, min_ones, sec_tens, sec_ones, blink_min, blink_sec, mode
  );

  modport slave (
    input  tick_1hz, tick_2hz, clr_d, pause_d, adj_d, sel_d,
    output min_tens, min_ones, sec_tens, sec_ones, blink_min, blink_sec, mode
  );

endinterface

// File: rtl/stopwatch_bcd60_cnt.sv
// Two-digit BCD counter 00..59 with clear (priority over increment) and a
// combinational carry flagging the 59 -> 00 wrap in the current cycle.
module bcd60_cnt
  import stopwatch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] ones,
  output logic               carry
);

  logic [DIGIT_W-1:0] tens_q, tens_d;
  logic [DIGIT_W-1:0] ones_q, ones_d;
  logic               at_max;

  // >= rather than == so an out-of-range value can never persist
  assign at_max = (tens_q >= TENS_MAX) && (ones_q >= ONES_MAX);
  assign carry  = inc && at_max;
  assign tens   = tens_q;
  assign ones   = ones_q;

  // Next digit values: clear, else ripple the ones digit into the tens digit
  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (clr) begin
      tens_d = '0;
      ones_d = '0;
    end else if (inc) begin
      if (ones_q >= ONES_MAX) begin
        ones_d = '0;
        if (tens_q >= TENS_MAX) begin
          tens_d = '0;
        end else begin
          tens_d = tens_q + 4'd1;
        end
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  // Digit registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: four-mode FSM (run, paused, adjust minutes, adjust
// seconds) steering two BCD 00..59 counters. The counter action is taken from
// the registered mode, so switch changes act one cycle later.
// Optional feature macro: STOPWATCH_BLINK_EN adds a blink phase register that
// blanks the field being adjusted; without it both blink outputs are 0.
module stopwatch_ctrl
  import stopwatch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_1hz,
  input  logic               tick_2hz,
  input  logic               clr_d,
  input  logic               pause_d,
  input  logic               adj_d,
  input  logic               sel_d,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic               blink_min,
  output logic               blink_sec,
  output logic [1:0]         mode
);

  sw_state_e state_q, state_d;
  logic      sec_inc;
  logic      min_inc;
  logic      sec_carry;
  logic      min_carry_unused;  // minute wrap has nowhere to go

  // Next mode follows the switches every cycle, no intermediate states
  always_comb begin
    state_d = next_mode(adj_d, sel_d, pause_d);
  end

  // Mode register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign mode = state_q;

  // Seconds advance on the 1 Hz tick when running, on the 2 Hz tick in ADJ_SEC
  always_comb begin
    sec_inc = 1'b0;
    case (state_q)
      ST_RUN:     sec_inc = tick_1hz;
      ST_ADJ_SEC: sec_inc = tick_2hz;
      default:    sec_inc = 1'b0;
    endcase
  end

  // Minutes take the seconds carry only when running (adjusting never carries)
  assign min_inc = ((state_q == ST_RUN) && sec_carry) ||
                   ((state_q == ST_ADJ_MIN) && tick_2hz);

  bcd60_cnt u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_d),
    .inc   (sec_inc),
    .tens  (sec_tens),
    .ones  (sec_ones),
    .carry (sec_carry)
  );

  bcd60_cnt u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_d),
    .inc   (min_inc),
    .tens  (min_tens),
    .ones  (min_ones),
    .carry (min_carry_unused)
  );

`ifdef STOPWATCH_BLINK_EN
  logic phase_q, phase_d;

  // Phase toggles on each 2 Hz tick while heading into an adjust mode and is
  // forced to 0 on the edge that enters any non-adjust mode
  always_comb begin
    phase_d = 1'b0;
    if (is_adj(state_d)) begin
      phase_d = phase_q ^ tick_2hz;
    end
  end

  // Blink phase register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign blink_min = phase_q && (state_q == ST_ADJ_MIN);
  assign blink_sec = phase_q && (state_q == ST_ADJ_SEC);
`else
  assign blink_min = 1'b0;
  assign blink_sec = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Testbench for stopwatch_ctrl: directed scenarios followed by randomized
// switch/tick traffic, every cycle compared against a time-arithmetic model.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  stopwatch_if sw_if ();

  stopwatch_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_1hz  (sw_if.tick_1hz),
    .tick_2hz  (sw_if.tick_2hz),
    .clr_d     (sw_if.clr_d),
    .pause_d   (sw_if.pause_d),
    .adj_d     (sw_if.adj_d),
    .sel_d     (sw_if.sel_d),
    .min_tens  (sw_if.min_tens),
    .min_ones  (sw_if.min_ones),
    .sec_tens  (sw_if.sec_tens),
    .sec_ones  (sw_if.sec_ones),
    .blink_min (sw_if.blink_min),
    .blink_sec (sw_if.blink_sec),
    .mode      (sw_if.mode)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: minutes, seconds, mode number (0 run, 1 paused,
  // 2 adjust minutes, 3 adjust seconds) and blink phase
  int m_min   = 0;
  int m_sec   = 0;
  int m_mode  = 0;
  int m_phase = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pack_bcd(input int mm, input int ss);
    return (mm / 10) * 4096 + (mm % 10) * 256 + (ss / 10) * 16 + (ss % 10);
  endfunction

  function automatic int obs_digits();
    return int'({sw_if.min_tens, sw_if.min_ones, sw_if.sec_tens, sw_if.sec_ones});
  endfunction

  // one clock: advance the model with the inputs present at the edge, then
  // compare digits, mode and blink 1 time unit later
  task automatic cycle();
    int t1, t2, cur, nxt, tot, exp_blink;
    @(posedge clk);
    t1 = int'(sw_if.tick_1hz);
    t2 = int'(sw_if.tick_2hz);
    if (!rst_n) begin
      m_min = 0; m_sec = 0; m_mode = 0; m_phase = 0;
    end else begin
      cur = m_mode;
      if (sw_if.clr_d) begin
        m_min = 0; m_sec = 0;
      end else if (cur == 0 && t1 == 1) begin
        tot   = (m_min * 60 + m_sec + 1) % 3600;
        m_min = tot / 60;
        m_sec = tot % 60;
      end else if (cur == 2 && t2 == 1) begin
        m_min = (m_min + 1) % 60;
      end else if (cur == 3 && t2 == 1) begin
        m_sec = (m_sec + 1) % 60;
      end
      nxt     = sw_if.adj_d ? (sw_if.sel_d ? 3 : 2) : (sw_if.pause_d ? 1 : 0);
      m_phase = (nxt >= 2) ? (m_phase ^ t2) : 0;
      m_mode  = nxt;
    end
    #1;
`ifdef STOPWATCH_BLINK_EN
    exp_blink = ((m_mode == 2 && m_phase == 1) ? 2 : 0) +
                ((m_mode == 3 && m_phase == 1) ? 1 : 0);
`else
    exp_blink = 0;
`endif
    check_val("digits", obs_digits(), pack_bcd(m_min, m_sec));
    check_val("mode", int'(sw_if.mode), m_mode);
    check_val("blink", int'({sw_if.blink_min, sw_if.blink_sec}), exp_blink);
  endtask

  task automatic pulse(input logic t1, input logic t2, input logic clr);
    sw_if.tick_1hz = t1;
    sw_if.tick_2hz = t2;
    sw_if.clr_d    = clr;
    cycle();
    sw_if.tick_1hz = 1'b0;
    sw_if.tick_2hz = 1'b0;
    sw_if.clr_d    = 1'b0;
  endtask

  task automatic idle();
    cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int toggles;
    int bs_seen;
    logic prev_bm;

    sw_if.tick_1hz = 1'b0;
    sw_if.tick_2hz = 1'b0;
    sw_if.clr_d    = 1'b0;
    sw_if.pause_d  = 1'b0;
    sw_if.adj_d    = 1'b0;
    sw_if.sel_d    = 1'b0;

    // reset
    rst_n = 1'b0;
    idle(); idle();
    rst_n = 1'b1;
    check_val("rst_digits", obs_digits(), 0);
    check_val("rst_mode", int'(sw_if.mode), 0);

    // 61 seconds of running
    repeat (61) begin pulse(1'b1, 1'b0, 1'b0); idle(); end
    check_val("run61", obs_digits(), 16'h0101);

    // preload 59:59 via adjust, then wrap to 00:00
    sw_if.adj_d = 1'b1; sw_if.sel_d = 1'b0; idle();
    for (int i = 0; i < 100 && m_min != 59; i++) pulse(1'b0, 1'b1, 1'b0);
    sw_if.sel_d = 1'b1; idle();
    for (int i = 0; i < 100 && m_sec != 59; i++) pulse(1'b0, 1'b1, 1'b0);
    check_val("preload", obs_digits(), 16'h5959);
    sw_if.adj_d = 1'b0; sw_if.sel_d = 1'b0; idle();
    check_val("back_run", int'(sw_if.mode), 0);
    pulse(1'b1, 1'b0, 1'b0);
    check_val("wrap_5959", obs_digits(), 16'h0000);

    // pause holds digits against both ticks
    repeat (3) pulse(1'b1, 1'b0, 1'b0);
    sw_if.pause_d = 1'b1; idle(); idle();
    repeat (5) pulse(1'b1, 1'b0, 1'b0);
    repeat (5) pulse(1'b0, 1'b1, 1'b0);
    check_val("pause_hold", obs_digits(), 16'h0003);
    check_val("pause_mode", int'(sw_if.mode), 1);
    sw_if.pause_d = 1'b0;

    // adjust seconds from 00:58: wraps without carry, 1 Hz ignored
    pulse(1'b0, 1'b0, 1'b1);
    sw_if.adj_d = 1'b1; sw_if.sel_d = 1'b1; idle();
    repeat (58) pulse(1'b0, 1'b1, 1'b0);
    check_val("preload_58", obs_digits(), 16'h0058);
    repeat (3) begin pulse(1'b0, 1'b1, 1'b0); pulse(1'b1, 1'b0, 1'b0); end
    check_val("adj_sec_wrap", obs_digits(), 16'h0001);

    // 12:34 then clear coinciding with a 1 Hz tick
    pulse(1'b0, 1'b0, 1'b1);
    sw_if.sel_d = 1'b0; idle();
    repeat (12) pulse(1'b0, 1'b1, 1'b0);
    sw_if.sel_d = 1'b1; idle();
    repeat (34) pulse(1'b0, 1'b1, 1'b0);
    check_val("preload_1234", obs_digits(), 16'h1234);
    sw_if.adj_d = 1'b0; sw_if.sel_d = 1'b0; idle();
    pulse(1'b1, 1'b0, 1'b1);
    check_val("clr_over_tick", obs_digits(), 16'h0000);

    // reset in the middle of adjusting leaves nothing behind
    sw_if.adj_d = 1'b1; idle();
    repeat (3) pulse(1'b0, 1'b1, 1'b0);
    rst_n = 1'b0; pulse(1'b0, 1'b1, 1'b0); rst_n = 1'b1;
    check_val("rst_mid_adj", obs_digits(), 16'h0000);
    check_val("rst_mid_adj_mode", int'(sw_if.mode), 0);

`ifdef STOPWATCH_BLINK_EN
    // blink_min toggles with each 2 Hz tick in ADJ_MIN, blink_sec stays low
    idle();
    toggles = 0; bs_seen = 0; prev_bm = sw_if.blink_min;
    repeat (4) begin
      pulse(1'b0, 1'b1, 1'b0);
      if (sw_if.blink_min != prev_bm) toggles++;
      prev_bm = sw_if.blink_min;
      if (sw_if.blink_sec) bs_seen = 1;
    end
    check_val("blink_toggles", toggles, 4);
    check_val("blink_sec_low", bs_seen, 0);
    check_val("blink_digits", obs_digits(), 16'h0400);
    pulse(1'b0, 1'b1, 1'b0);
    rst_n = 1'b0; pulse(1'b0, 1'b1, 1'b0); rst_n = 1'b1;
    check_val("blink_rst", int'({sw_if.blink_min, sw_if.blink_sec}), 0);
    check_val("blink_rst_digits", obs_digits(), 16'h0000);
`endif

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst_n          = ($urandom_range(0, 99) != 0);
      sw_if.tick_1hz = ($urandom_range(0, 2) == 0);
      sw_if.tick_2hz = ($urandom_range(0, 2) == 0);
      sw_if.clr_d    = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 7) == 0) sw_if.pause_d = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 9) == 0) sw_if.adj_d   = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 9) == 0) sw_if.sel_d   = $urandom_range(0, 1) == 1;
      cycle();
    end
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all logic on posedge.
REQ-002 SHALL have ports: rst_n  in  1  one clock; reset is synchronous and active-low.
REQ-003 SHALL have ports: tick_1hz  in  1  one-cycle count-enable pulse, clk domain.
REQ-004 SHALL have ports: tick_2hz  in  1  one-cycle adjust/blink pulse, clk domain.
REQ-005 SHALL have ports: clr_d  in  1  debounced clear button, level, active-high.
REQ-006 SHALL have ports: pause_d  in  1  debounced pause toggle level, 1 = paused.
REQ-007 SHALL have ports: adj_d  in  1  debounced adjust switch, 1 = adjust mode.
REQ-008 SHALL have ports: sel_d  in  1  adjust field select, 0 = minutes, 1 = seconds.
REQ-009 SHALL have ports: min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD digits.
REQ-010 SHALL have ports: blink_min, blink_sec  out  1 each  digit-group blank request.
REQ-011 SHALL have ports: mode  out  2  registered state, encoded per package.

Function
REQ-012 SHALL hold a registered FSM with states RUN, PAUSED, ADJ_MIN, ADJ_SEC.
REQ-013 SHALL compute the next state every cycle with priority adj_d (ADJ_SEC if sel_d, else ADJ_MIN) > pause_d (PAUSED) > RUN.
REQ-014 SHALL allow any state to reach any other state in one cycle; no intermediate states.
REQ-015 SHALL select counter action from the registered state, giving one cycle of input-to-action latency.
REQ-016 SHALL, in RUN on tick_1hz, increment seconds with updated digits visible after that edge; 59 wraps to 00 and carries +1 to minutes in the same edge.
REQ-017 SHALL wrap 59:59 to 00:00 on the next tick_1hz in RUN; no overflow flag.
REQ-018 SHALL hold all digits in PAUSED and ignore both ticks.
REQ-019 SHALL, in ADJ_MIN on tick_2hz, increment minutes only (59 to 00), with seconds held and no carry.
REQ-020 SHALL, in ADJ_SEC on tick_2hz, increment seconds only (59 to 00), with no carry into minutes.
REQ-021 SHALL ignore tick_1hz in ADJ states and ignore tick_2hz in RUN.
REQ-022 SHALL zero all digits at the next edge while clr_d is high, in any state, overriding any same-cycle tick; the FSM keeps following REQ-013.
REQ-023 SHALL keep every digit in 0-9 and every tens digit in 0-5 at all times.

Reset
REQ-024 SHALL, on a clock edge with rst_n low, set all digits to 0, mode to RUN, and blink_min/blink_sec to 0.
REQ-025 SHALL give rst_n priority over clr_d and all ticks.
REQ-026 SHALL, when rst_n is asserted mid-adjust or mid-carry, leave no partial update visible after the reset edge.

Configuration
REQ-027 SHALL, with STOPWATCH_BLINK_EN defined, toggle an internal blink phase on each tick_2hz.
REQ-028 SHALL drive blink_min = phase only in ADJ_MIN and blink_sec = phase only in ADJ_SEC.
REQ-029 SHALL clear the blink phase to 0 on entry to any non-ADJ state.
REQ-030 SHALL, with STOPWATCH_BLINK_EN undefined, tie blink_min and blink_sec to 0 and remove the phase register.

Structure
REQ-031 SHALL place the state encoding (RUN=0, PAUSED=1, ADJ_MIN=2, ADJ_SEC=3), the BCD max constants (tens 5, ones 9) and the digit width in shared package stopwatch_pkg.
REQ-032 SHALL instantiate sub-module bcd60_cnt twice (seconds, minutes).
REQ-033 SHALL give bcd60_cnt ports clk, rst_n, clr, inc, tens, ones and carry, where carry is combinational and high when inc is high and the value is 59.

Verification
REQ-034 SHALL check: reset, then 61 tick_1hz pulses in RUN -> 01:01.
REQ-035 SHALL check: preload 59:59 via adjust, return to RUN, one tick_1hz -> 00:00.
REQ-036 SHALL check: pause_d=1 for 2 cycles, then 5 ticks of each rate -> digits unchanged and mode=PAUSED.
REQ-037 SHALL check: adj_d=1, sel_d=1 from 00:58, then 3 tick_2hz -> 00:01 with minutes unchanged; tick_1hz has no effect.
REQ-038 SHALL check: clr_d pulsed in the same cycle as tick_1hz at 12:34 -> 00:00 at the next edge.
REQ-039 SHALL check: with STOPWATCH_BLINK_EN, ADJ_MIN plus 4 tick_2hz -> blink_min toggles 4 times and blink_sec stays 0; rst_n low mid-sequence -> blink and digits go to 0 at the next edge.
